ahb3lite_mem_slave: RTL and testbench

//  AHB3-Lite slave responder backed by an internal byte-addressable RAM. It is the

---
 rtl/ahb3lite_pkg.sv | 61 ++++++
 rtl/ahb3lite_mem_slave_if.sv | 32 +++
 rtl/ahb3lite_mem_slave_ram.sv | 31 +++
 rtl/ahb3lite_mem_slave.sv | 130 +++++++++++++
 tb/tb_ahb3lite_mem_slave.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and helpers.
// Holds HTRANS/HSIZE/HRESP/HBURST codes, byte-enable and alignment helpers.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_B8    = 3'b000;
    localparam logic [2:0] HSIZE_B16   = 3'b001;
    localparam logic [2:0] HSIZE_B32   = 3'b010;
    localparam logic [2:0] HSIZE_B64   = 3'b011;
    localparam logic [2:0] HSIZE_B128  = 3'b100;
    localparam logic [2:0] HSIZE_B256  = 3'b101;
    localparam logic [2:0] HSIZE_B512  = 3'b110;
    localparam logic [2:0] HSIZE_B1024 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Little-endian lane mask for up to 8 lanes; callers slice to width.
    function automatic logic [7:0] byte_en(
        input logic [2:0] size,
        input logic [2:0] lo
    );
        logic [7:0] m;
        unique case (size)
            HSIZE_B8:  m = 8'h01;
            HSIZE_B16: m = 8'h03;
            HSIZE_B32: m = 8'h0F;
            default:   m = 8'hFF;
        endcase
        return m << lo;
    endfunction

    function automatic logic size_aligned(
        input logic [2:0] size,
        input logic [2:0] lo
    );
        logic ok;
        unique case (size)
            HSIZE_B8:  ok = 1'b1;
            HSIZE_B16: ok = ~lo[0];
            HSIZE_B32: ok = (lo[1:0] == 2'b00);
            HSIZE_B64: ok = (lo == 3'b000);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb3lite_mem_slave_if.sv
// AHB3-Lite slave port bundle.
// master drives address/control/write data; slave returns data/ready/resp.
interface ahb3lite_mem_slave_if #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST,
        output HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST,
        input  HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3lite_mem_slave_ram.sv
// Word-wide RAM with per-byte write enable and registered read.
// Ports: clk, rst (read reg only), we/waddr/wdata, re/raddr/rdata.
module ahb3lite_mem_slave_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W/8-1:0] we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic [DATA_W-1:0]   rdata
);
    localparam int LANES = DATA_W / 8;
    localparam int WORDS = 1 << AW;

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite memory slave: FSM, wait counter, error check, RAW forward.
// Ports: HCLK, HRESET (async, high), bus (slave modport).
module ahb3lite_mem_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0
) (
    input logic HCLK,
    input logic HRESET,
    ahb3lite_mem_slave_if.slave bus
);
    localparam int LANES     = HDATA_SIZE / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int MEM_AW    = $clog2(MEM_BYTES);
    localparam int WORD_AW   = MEM_AW - LANE_BITS;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]            state, state_nx;
    logic [3:0]            cnt;
    logic [MEM_AW-1:0]     addr_q;
    logic [2:0]            size_q;
    logic                  wr_q;
    logic                  open_st, acc, take, err;
    logic                  do_write, ram_re, hazard;
    logic [7:0]            be_all;
    logic [LANES-1:0]      wr_be, fwd_be;
    logic [WORD_AW-1:0]    raddr, waddr;
    logic [HDATA_SIZE-1:0] ram_rdata, fwd_data, hrdata;

    // States that can take a new address phase.
    assign open_st = (state == S_IDLE) || (state == S_DATA)
                  || (state == S_ERR2);
    assign acc  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign take = open_st & acc;

    assign err = ({1'b0, bus.HADDR}
                  >= (HADDR_SIZE+1)'(MEM_BYTES))
               | (bus.HSIZE > 3'(LANE_BITS))
               | ~size_aligned(bus.HSIZE, bus.HADDR[2:0]);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_WAIT: if (cnt == 4'd0) state_nx = S_DATA;
            S_ERR1: state_nx = S_ERR2;
            default: begin
                state_nx = S_IDLE;
                if (take) begin
                    if (err)                  state_nx = S_ERR1;
                    else if (WAIT_STATES > 0) state_nx = S_WAIT;
                    else                      state_nx = S_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            wr_q     <= 1'b0;
            fwd_be   <= '0;
            fwd_data <= '0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT) cnt <= cnt - 4'd1;
            if (take) begin
                addr_q <= bus.HADDR[MEM_AW-1:0];
                size_q <= bus.HSIZE;
                wr_q   <= bus.HWRITE;
                cnt    <= 4'(WAIT_STATES - 1);
            end
            // Capture write lanes that the RAM read at this edge misses.
            if (ram_re) begin
                fwd_be   <= hazard ? wr_be : '0;
                fwd_data <= bus.HWDATA;
            end
        end
    end

    assign do_write = (state == S_DATA) & wr_q;
    assign be_all   = byte_en(size_q, 3'(addr_q[LANE_BITS-1:0]));
    assign wr_be    = do_write ? be_all[LANES-1:0] : '0;
    assign waddr    = addr_q[MEM_AW-1:LANE_BITS];
    // WAIT re-reads the latched word; otherwise read the new address.
    assign raddr    = (state == S_WAIT) ? waddr
                    : bus.HADDR[MEM_AW-1:LANE_BITS];
    assign ram_re   = (take & ~err & ~bus.HWRITE)
                    | ((state == S_WAIT) & ~wr_q);
    assign hazard   = do_write & (raddr == waddr);

    ahb3lite_mem_slave_ram #(
        .DATA_W (HDATA_SIZE),
        .AW     (WORD_AW)
    ) u_ram (
        .clk   (HCLK),
        .rst   (HRESET),
        .we    (wr_be),
        .waddr (waddr),
        .wdata (bus.HWDATA),
        .re    (ram_re),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        hrdata = ram_rdata;
        for (int i = 0; i < LANES; i++) begin
            if (fwd_be[i]) hrdata[8*i +: 8] = fwd_data[8*i +: 8];
        end
    end

    assign bus.HRDATA    = hrdata;
    assign bus.HREADYOUT = ~((state == S_WAIT) || (state == S_ERR1));
    assign bus.HRESP     = ((state == S_ERR1) || (state == S_ERR2))
                         ? HRESP_ERROR : HRESP_OKAY;

    logic unused_ok;
    assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, be_all};
endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Directed bench for ahb3lite_mem_slave at 0 and 3 wait states.
// Table of single transfers plus hand sequences for multi-cycle cases.
module tb_ahb3lite_mem_slave;
    import ahb3lite_pkg::*;

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 18;

    logic clk;
    logic rst0, rst3;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NV];

    ahb3lite_mem_slave_if #(.HADDR_SIZE(16), .HDATA_SIZE(32)) b0 ();
    ahb3lite_mem_slave_if #(.HADDR_SIZE(16), .HDATA_SIZE(32)) b3 ();

    assign b0.HREADY = b0.HREADYOUT;
    assign b3.HREADY = b3.HREADYOUT;

    ahb3lite_mem_slave #(.WAIT_STATES(0)) u_dut0 (
        .HCLK   (clk),
        .HRESET (rst0),
        .bus    (b0.slave)
    );

    ahb3lite_mem_slave #(.WAIT_STATES(3)) u_dut3 (
        .HCLK   (clk),
        .HRESET (rst3),
        .bus    (b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic run0(input vec_t v, input string nm);
        @(posedge clk); #1;
        b0.HSEL   = 1'b1;
        b0.HTRANS = HTRANS_NONSEQ;
        b0.HWRITE = v.wr;
        b0.HSIZE  = v.size;
        b0.HADDR  = v.addr;
        @(posedge clk); #1;
        b0.HTRANS = HTRANS_IDLE;
        b0.HWDATA = v.wdata;
        @(negedge clk);
        if (v.err) begin
            check({nm, "_err1_rdy"}, 32'(b0.HREADYOUT), 32'd0);
            check({nm, "_err1_resp"}, 32'(b0.HRESP), 32'd1);
            @(negedge clk);
            check({nm, "_err2_rdy"}, 32'(b0.HREADYOUT), 32'd1);
            check({nm, "_err2_resp"}, 32'(b0.HRESP), 32'd1);
        end else begin
            check({nm, "_rdy"}, 32'(b0.HREADYOUT), 32'd1);
            check({nm, "_resp"}, 32'(b0.HRESP), 32'd0);
        end
        if (v.chk) check({nm, "_rdata"}, b0.HRDATA, v.exp);
    endtask

    task automatic wait_rdy3(output int lows);
        bit done;
        done = 1'b0;
        lows = 0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (b3.HREADYOUT) done = 1'b1;
            else              lows++;
        end
        if (!done) begin
            errors++;
            $display("FAIL ws3_timeout: HREADYOUT stuck low");
        end
    endtask

    task automatic xfer3(input logic wr, input logic [15:0] a,
                         input logic [31:0] wd, output int lows);
        @(posedge clk); #1;
        b3.HSEL   = 1'b1;
        b3.HTRANS = HTRANS_NONSEQ;
        b3.HWRITE = wr;
        b3.HSIZE  = HSIZE_B32;
        b3.HADDR  = a;
        @(posedge clk); #1;
        b3.HTRANS = HTRANS_IDLE;
        b3.HWDATA = wd;
        wait_rdy3(lows);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lows;
        vec_t v;

        vecs[0]  = '{1'b1, HSIZE_B32, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, HSIZE_B32, 16'h0010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, HSIZE_B8,  16'h0020, 32'hAAAAAA11, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, HSIZE_B8,  16'h0021, 32'hAAAA22AA, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, HSIZE_B8,  16'h0022, 32'hAA33AAAA, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, HSIZE_B8,  16'h0023, 32'h44AAAAAA, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, HSIZE_B32, 16'h0020, 32'h0, 1'b0, 1'b1, 32'h44332211};
        vecs[7]  = '{1'b1, HSIZE_B16, 16'h0012, 32'h12345678, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, HSIZE_B32, 16'h0010, 32'h0, 1'b0, 1'b1, 32'h1234BEEF};
        vecs[9]  = '{1'b1, HSIZE_B32, 16'h0000, 32'h01020304, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, HSIZE_B32, 16'h1000, 32'h0, 1'b1, 1'b1, 32'h1234BEEF};
        vecs[11] = '{1'b1, HSIZE_B16, 16'h0021, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{1'b1, HSIZE_B64, 16'h0020, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
        vecs[13] = '{1'b1, HSIZE_B32, 16'h1000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{1'b0, HSIZE_B32, 16'h0020, 32'h0, 1'b0, 1'b1, 32'h44332211};
        vecs[15] = '{1'b0, HSIZE_B32, 16'h0000, 32'h0, 1'b0, 1'b1, 32'h01020304};
        vecs[16] = '{1'b0, HSIZE_B8,  16'h0023, 32'h0, 1'b0, 1'b1, 32'h44332211};
        vecs[17] = '{1'b1, HSIZE_B32, 16'h0030, 32'h11111111, 1'b0, 1'b0, 32'h0};

        b0.HSEL = 1'b0;  b0.HADDR = '0;  b0.HWDATA = '0;
        b0.HWRITE = 1'b0; b0.HSIZE = HSIZE_B32;
        b0.HBURST = HBURST_SINGLE; b0.HPROT = 4'h3;
        b0.HTRANS = HTRANS_IDLE; b0.HMASTLOCK = 1'b0;
        b3.HSEL = 1'b0;  b3.HADDR = '0;  b3.HWDATA = '0;
        b3.HWRITE = 1'b0; b3.HSIZE = HSIZE_B32;
        b3.HBURST = HBURST_SINGLE; b3.HPROT = 4'h3;
        b3.HTRANS = HTRANS_IDLE; b3.HMASTLOCK = 1'b0;
        rst0 = 1'b1;
        rst3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        check("rst0_rdy", 32'(b0.HREADYOUT), 32'd1);
        check("rst0_resp", 32'(b0.HRESP), 32'd0);
        check("rst0_rdata", b0.HRDATA, 32'd0);
        check("rst3_rdy", 32'(b3.HREADYOUT), 32'd1);
        check("rst3_resp", 32'(b3.HRESP), 32'd0);
        check("rst3_rdata", b3.HRDATA, 32'd0);

        for (int i = 0; i < NV; i++) begin
            run0(vecs[i], $sformatf("vec%0d", i));
        end

        // Full-word write followed at once by a read of the same word.
        @(posedge clk); #1;
        b0.HSEL = 1'b1; b0.HTRANS = HTRANS_NONSEQ;
        b0.HWRITE = 1'b1; b0.HSIZE = HSIZE_B32; b0.HADDR = 16'h0030;
        @(posedge clk); #1;
        b0.HWDATA = 32'hA5A5A5A5;
        b0.HWRITE = 1'b0; b0.HADDR = 16'h0030;
        @(posedge clk); #1;
        b0.HTRANS = HTRANS_IDLE;
        @(negedge clk);
        check("raw_word_rdy", 32'(b0.HREADYOUT), 32'd1);
        check("raw_word_rdata", b0.HRDATA, 32'hA5A5A5A5);

        // Byte write then read: only lane 1 forwarded.
        @(posedge clk); #1;
        b0.HTRANS = HTRANS_NONSEQ; b0.HWRITE = 1'b1;
        b0.HSIZE = HSIZE_B8; b0.HADDR = 16'h0031;
        @(posedge clk); #1;
        b0.HWDATA = 32'hEEEE77EE;
        b0.HWRITE = 1'b0; b0.HSIZE = HSIZE_B32; b0.HADDR = 16'h0030;
        @(posedge clk); #1;
        b0.HTRANS = HTRANS_IDLE;
        @(negedge clk);
        check("raw_byte_rdata", b0.HRDATA, 32'hA5A577A5);

        // BUSY and deselected NONSEQ get zero-wait OKAY and no effect.
        @(posedge clk); #1;
        b0.HTRANS = HTRANS_BUSY;
        @(negedge clk);
        check("busy_rdy", 32'(b0.HREADYOUT), 32'd1);
        check("busy_resp", 32'(b0.HRESP), 32'd0);
        check("busy_rdata", b0.HRDATA, 32'hA5A577A5);
        @(posedge clk); #1;
        b0.HSEL = 1'b0; b0.HTRANS = HTRANS_NONSEQ;
        b0.HWRITE = 1'b1; b0.HADDR = 16'h0030;
        @(posedge clk); #1;
        b0.HTRANS = HTRANS_IDLE; b0.HWDATA = 32'h00000000;
        @(negedge clk);
        check("nosel_rdy", 32'(b0.HREADYOUT), 32'd1);
        check("nosel_resp", 32'(b0.HRESP), 32'd0);
        v = '{1'b0, HSIZE_B32, 16'h0030, 32'h0, 1'b0, 1'b1, 32'hA5A577A5};
        run0(v, "nosel_after");

        // Three wait states: write, then read with back-to-back write.
        xfer3(1'b1, 16'h0010, 32'hCAFEF00D, lows);
        check("ws3_wr_lows", 32'(lows), 32'd3);
        @(posedge clk); #1;
        b3.HSEL = 1'b1; b3.HTRANS = HTRANS_NONSEQ;
        b3.HWRITE = 1'b0; b3.HSIZE = HSIZE_B32; b3.HADDR = 16'h0010;
        @(posedge clk); #1;
        b3.HWRITE = 1'b1; b3.HADDR = 16'h0014;
        wait_rdy3(lows);
        check("ws3_rd_lows", 32'(lows), 32'd3);
        check("ws3_rd_resp", 32'(b3.HRESP), 32'd0);
        check("ws3_rd_rdata", b3.HRDATA, 32'hCAFEF00D);
        @(posedge clk); #1;
        b3.HTRANS = HTRANS_IDLE; b3.HWDATA = 32'h0BADCAFE;
        wait_rdy3(lows);
        check("ws3_b2b_lows", 32'(lows), 32'd3);
        xfer3(1'b0, 16'h0014, 32'h0, lows);
        check("ws3_b2b_rdata", b3.HRDATA, 32'h0BADCAFE);

        // Error with wait states is still two cycles.
        @(posedge clk); #1;
        b3.HTRANS = HTRANS_NONSEQ; b3.HWRITE = 1'b0; b3.HADDR = 16'h1000;
        @(posedge clk); #1;
        b3.HTRANS = HTRANS_IDLE;
        @(negedge clk);
        check("ws3_err1_rdy", 32'(b3.HREADYOUT), 32'd0);
        check("ws3_err1_resp", 32'(b3.HRESP), 32'd1);
        @(negedge clk);
        check("ws3_err2_rdy", 32'(b3.HREADYOUT), 32'd1);
        check("ws3_err2_resp", 32'(b3.HRESP), 32'd1);

        // Reset during a waited write drops the write.
        xfer3(1'b1, 16'h0018, 32'h55AA55AA, lows);
        @(posedge clk); #1;
        b3.HTRANS = HTRANS_NONSEQ; b3.HWRITE = 1'b1; b3.HADDR = 16'h0018;
        @(posedge clk); #1;
        b3.HTRANS = HTRANS_IDLE; b3.HWDATA = 32'hFFFFFFFF;
        @(negedge clk);
        check("rstw_wait_rdy", 32'(b3.HREADYOUT), 32'd0);
        #2 rst3 = 1'b1;
        #1;
        check("rstw_rdy", 32'(b3.HREADYOUT), 32'd1);
        check("rstw_resp", 32'(b3.HRESP), 32'd0);
        check("rstw_rdata", b3.HRDATA, 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        xfer3(1'b0, 16'h0018, 32'h0, lows);
        check("rstw_after_lows", 32'(lows), 32'd3);
        check("rstw_after_rdata", b3.HRDATA, 32'h55AA55AA);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
